// File: rtl/vga_axil_slave.sv
// AXI4-Lite slave front end for the VGA controller.
// Terminates AW/W/B/AR/R and presents a simple strobe interface to the core:
// a registered write (addr/data/strb + one-cycle wready pulse) and a read
// request with a fixed-latency sample of the core's read data.
module vga_axil_slave #(
    parameter int          C_AXI_DATA_WIDTH = 32,
    parameter int          C_AXI_ADDR_WIDTH = 15,
    parameter int          RD_LATENCY       = 4,
    parameter logic [14:0] BUF_LIMIT        = 15'h4960
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    // write address channel
    input  logic                          s_axil_awvalid,
    output logic                          s_axil_awready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]                    s_axil_awprot,
    // write data channel
    input  logic                          s_axil_wvalid,
    output logic                          s_axil_wready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
    // write response channel
    output logic                          s_axil_bvalid,
    input  logic                          s_axil_bready,
    output logic [1:0]                    s_axil_bresp,
    // read address channel
    input  logic                          s_axil_arvalid,
    output logic                          s_axil_arready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]                    s_axil_arprot,
    // read data channel
    output logic                          s_axil_rvalid,
    input  logic                          s_axil_rready,
    output logic [C_AXI_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                    s_axil_rresp,
    // core side
    output logic [C_AXI_ADDR_WIDTH-1:0]   axil_waddr_o,
    output logic [C_AXI_DATA_WIDTH-1:0]   axil_wdata_o,
    output logic [C_AXI_DATA_WIDTH/8-1:0] axil_wstrb_o,
    output logic                          axil_wready_o,
    output logic                          axil_rreq_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]   axil_raddr_o,
    input  logic [C_AXI_DATA_WIDTH-1:0]   axil_rdata_i
);

    localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

    // protection bits carry no meaning for this block
    logic unused_prot;
    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    assign s_axil_rresp = 2'b00;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic                        aw_full, w_full;
    logic                        aw_full_d, w_full_d;
    logic [C_AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [C_AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]           w_strb;
    logic                        aw_hs, w_hs, b_hs, issue, addr_bad;

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid  && s_axil_wready;
    assign b_hs  = s_axil_bvalid  && s_axil_bready;
    assign issue = aw_full && w_full && !s_axil_bvalid;

    // Buffer region (bit 14) is only backed up to BUF_LIMIT; anything at or
    // past it inside that region is rejected with SLVERR.
    assign addr_bad = aw_addr[14] && (aw_addr[13:0] >= BUF_LIMIT[13:0]);

    // Ready is a register of the inverted next full flag, so it drops the
    // cycle after a handshake and returns the cycle after issue.
    always_comb begin
        aw_full_d = aw_full;
        w_full_d  = w_full;
        if (issue) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end else begin
            if (aw_hs) aw_full_d = 1'b1;
            if (w_hs)  w_full_d  = 1'b1;
        end
    end

    // AW/W holding registers and their ready flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_full        <= 1'b0;
            w_full         <= 1'b0;
            aw_addr        <= '0;
            w_data         <= '0;
            w_strb         <= '0;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
        end else begin
            if (aw_hs) aw_addr <= s_axil_awaddr;
            if (w_hs) begin
                w_data <= s_axil_wdata;
                w_strb <= s_axil_wstrb;
            end
            aw_full        <= aw_full_d;
            w_full         <= w_full_d;
            s_axil_awready <= !aw_full_d;
            s_axil_wready  <= !w_full_d;
        end
    end

    // Core write registers, write pulse and B response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            axil_waddr_o  <= '0;
            axil_wdata_o  <= '0;
            axil_wstrb_o  <= '0;
            axil_wready_o <= 1'b0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= 2'b00;
        end else begin
            axil_wready_o <= issue && !addr_bad;
            if (issue) begin
                axil_waddr_o  <= aw_addr;
                axil_wdata_o  <= w_data;
                axil_wstrb_o  <= w_strb;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= addr_bad ? 2'b10 : 2'b00;
            end else if (b_hs) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rstate_t                     state, state_d;
    logic [CNT_W-1:0]            cnt, cnt_d;
    logic                        arready_d, rreq_d, rvalid_d;
    logic [C_AXI_DATA_WIDTH-1:0] rdata_d;
    logic [C_AXI_ADDR_WIDTH-1:0] raddr_d;
    logic                        ar_hs, r_hs;

    assign ar_hs = s_axil_arvalid && s_axil_arready;
    assign r_hs  = s_axil_rvalid  && s_axil_rready;

    // Read state and registered read outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= R_IDLE;
            cnt            <= '0;
            s_axil_arready <= 1'b0;
            axil_rreq_o    <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= '0;
            axil_raddr_o   <= '0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            s_axil_arready <= arready_d;
            axil_rreq_o    <= rreq_d;
            s_axil_rvalid  <= rvalid_d;
            s_axil_rdata   <= rdata_d;
            axil_raddr_o   <= raddr_d;
        end
    end

    // Read next-state logic; cnt==1 means the count hits zero this edge
    always_comb begin
        state_d = state;
        case (state)
            R_IDLE:  if (ar_hs)           state_d = R_WAIT;
            R_WAIT:  if (cnt == CNT_W'(1)) state_d = R_RESP;
            R_RESP:  if (r_hs)            state_d = R_IDLE;
            default:                      state_d = R_IDLE;
        endcase
    end

    // Read output next values: request pulse, latency count, data capture
    always_comb begin
        cnt_d     = cnt;
        arready_d = (state_d == R_IDLE);
        rreq_d    = 1'b0;
        rvalid_d  = s_axil_rvalid;
        rdata_d   = s_axil_rdata;
        raddr_d   = axil_raddr_o;
        case (state)
            R_IDLE: begin
                if (ar_hs) begin
                    raddr_d = s_axil_araddr;
                    cnt_d   = CNT_W'(RD_LATENCY);
                    rreq_d  = 1'b1;
                end
            end
            R_WAIT: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    rdata_d  = axil_rdata_i;
                    rvalid_d = 1'b1;
                end
            end
            R_RESP: begin
                if (r_hs) rvalid_d = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vga_axil_slave.sv
// Directed bench for vga_axil_slave: write/read handshakes, SLVERR boundary,
// concurrent traffic with B backpressure, and mid-transaction reset.
module tb_vga_axil_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [14:0] awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic [31:0] wdata = '0, rdata_i = '0;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, wdata_o;
    logic [14:0] waddr_o, raddr_o;
    logic [3:0]  wstrb_o;
    logic        wready_o, rreq;

    int checks = 0, fails = 0;
    int pulse_cnt = 0, b_cnt = 0;
    logic prev_pulse = 1'b0;

    always #5 clk = ~clk;

    vga_axil_slave dut (
        .clk_i(clk), .rst_i(rst),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr), .s_axil_awprot(awprot),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr), .s_axil_arprot(arprot),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .axil_waddr_o(waddr_o), .axil_wdata_o(wdata_o), .axil_wstrb_o(wstrb_o), .axil_wready_o(wready_o),
        .axil_rreq_o(rreq), .axil_raddr_o(raddr_o), .axil_rdata_i(rdata_i)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse accounting: every write pulse must coincide with bvalid and last one cycle
    always @(posedge clk) begin
        if (wready_o) begin
            pulse_cnt++;
            chk("pulse_has_b", 64'(bvalid), 64'(1));
            chk("pulse_1cyc", 64'(prev_pulse), 64'(0));
        end
        prev_pulse = wready_o;
        if (bvalid && bready) b_cnt++;
    end

    // AW and W presented together, B accepted right after it appears
    task automatic do_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] resp, input logic pulse);
        int p0;
        p0 = pulse_cnt;
        awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s; bready = 0;
        tick();
        awvalid = 0; wvalid = 0;
        chk("w_awready_low", 64'(awready), 64'(0));
        chk("w_no_early_pulse", 64'(wready_o), 64'(0));
        tick();
        chk("w_pulse", 64'(wready_o), 64'(pulse));
        chk("w_bvalid", 64'(bvalid), 64'(1));
        chk("w_bresp", 64'(bresp), 64'(resp));
        chk("w_waddr", 64'(waddr_o), 64'(a));
        chk("w_wdata", 64'(wdata_o), 64'(d));
        chk("w_wstrb", 64'(wstrb_o), 64'(s));
        chk("w_awready_back", 64'(awready), 64'(1));
        bready = 1;
        tick();
        bready = 0;
        chk("w_bvalid_clr", 64'(bvalid), 64'(0));
        chk("w_pulse_clr", 64'(wready_o), 64'(0));
        chk("w_pulse_cnt", 64'(pulse_cnt - p0), 64'(pulse));
    endtask

    initial begin
        int p0, b0;

        // reset state
        repeat (3) tick();
        chk("rst_awready", 64'(awready), 64'(0));
        chk("rst_wready", 64'(wready), 64'(0));
        chk("rst_arready", 64'(arready), 64'(0));
        chk("rst_bvalid", 64'(bvalid), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_wpulse", 64'(wready_o), 64'(0));
        chk("rst_rreq", 64'(rreq), 64'(0));
        rst = 0;
        chk("rel_awready", 64'(awready), 64'(0));
        tick();
        chk("rel_awready1", 64'(awready), 64'(1));
        chk("rel_wready1", 64'(wready), 64'(1));
        chk("rel_arready1", 64'(arready), 64'(1));

        // legal write, same-cycle AW/W
        do_write(15'h0008, 32'h0000_000F, 4'hF, 2'b00, 1'b1);

        // W three cycles ahead of AW
        p0 = pulse_cnt; b0 = b_cnt;
        wvalid = 1; wdata = 32'h1234_5678; wstrb = 4'h3;
        tick();
        wvalid = 0;
        chk("wf_wready0", 64'(wready), 64'(0));
        tick();
        chk("wf_wready1", 64'(wready), 64'(0));
        tick();
        chk("wf_wready2", 64'(wready), 64'(0));
        awvalid = 1; awaddr = 15'h4000;
        tick();
        awvalid = 0;
        chk("wf_wready3", 64'(wready), 64'(0));
        chk("wf_no_pulse", 64'(wready_o), 64'(0));
        chk("wf_no_b", 64'(bvalid), 64'(0));
        tick();
        chk("wf_pulse", 64'(wready_o), 64'(1));
        chk("wf_waddr", 64'(waddr_o), 64'h4000);
        chk("wf_wdata", 64'(wdata_o), 64'h1234_5678);
        chk("wf_wstrb", 64'(wstrb_o), 64'h3);
        chk("wf_bresp", 64'(bresp), 64'(0));
        chk("wf_wready_back", 64'(wready), 64'(1));
        bready = 1;
        tick();
        bready = 0;
        repeat (3) tick();
        chk("wf_one_pulse", 64'(pulse_cnt - p0), 64'(1));
        chk("wf_one_b", 64'(b_cnt - b0), 64'(1));
        chk("wf_b_idle", 64'(bvalid), 64'(0));

        // illegal and boundary addresses
        do_write(15'h4960, 32'h0000_CAFE, 4'hF, 2'b10, 1'b0);
        do_write(15'h495F, 32'hA5A5_0001, 4'h1, 2'b00, 1'b1);
        do_write(15'h0960, 32'h0BAD_F00D, 4'hC, 2'b00, 1'b1);

        // read with rready backpressure; core data valid only in the sample cycle
        arvalid = 1; araddr = 15'h0004; rready = 0; rdata_i = 32'hDEAD;
        tick();
        arvalid = 0;
        chk("r_rreq", 64'(rreq), 64'(1));
        chk("r_raddr", 64'(raddr_o), 64'h4);
        chk("r_arready_low", 64'(arready), 64'(0));
        tick();
        chk("r_rreq_clr", 64'(rreq), 64'(0));
        tick();
        chk("r_rvalid_t3", 64'(rvalid), 64'(0));
        tick();
        rdata_i = 32'h0000_000A;
        chk("r_rvalid_t4", 64'(rvalid), 64'(0));
        tick();
        rdata_i = 32'h0000_00BB;
        chk("r_rvalid", 64'(rvalid), 64'(1));
        chk("r_rdata", 64'(rdata), 64'hA);
        chk("r_rresp", 64'(rresp), 64'(0));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("r_hold_rvalid", 64'(rvalid), 64'(1));
            chk("r_hold_rdata", 64'(rdata), 64'hA);
            chk("r_hold_arready", 64'(arready), 64'(0));
        end
        rready = 1;
        tick();
        rready = 0;
        chk("r_rvalid_clr", 64'(rvalid), 64'(0));
        chk("r_arready_back", 64'(arready), 64'(1));
        chk("r_raddr_hold", 64'(raddr_o), 64'h4);

        // concurrent read and write, B held off for 4 cycles
        p0 = pulse_cnt;
        arvalid = 1; araddr = 15'h0010; rready = 1; rdata_i = 32'h77;
        awvalid = 1; awaddr = 15'h0020; wvalid = 1; wdata = 32'h55; wstrb = 4'hF; bready = 0;
        tick();
        arvalid = 0; awvalid = 0; wvalid = 0;
        chk("c_rreq", 64'(rreq), 64'(1));
        chk("c_raddr", 64'(raddr_o), 64'h10);
        tick();
        chk("c_pulse1", 64'(wready_o), 64'(1));
        chk("c_bvalid1", 64'(bvalid), 64'(1));
        chk("c_waddr1", 64'(waddr_o), 64'h20);
        awvalid = 1; awaddr = 15'h0024; wvalid = 1; wdata = 32'h66;
        tick();
        awvalid = 0; wvalid = 0;
        chk("c_aw2_taken", 64'(awready), 64'(0));
        chk("c_w2_taken", 64'(wready), 64'(0));
        tick();
        chk("c_blocked", 64'(wready_o), 64'(0));
        chk("c_waddr_hold", 64'(waddr_o), 64'h20);
        tick();
        chk("c_rvalid", 64'(rvalid), 64'(1));
        chk("c_rdata", 64'(rdata), 64'h77);
        chk("c_blocked2", 64'(wready_o), 64'(0));
        tick();
        chk("c_rvalid_clr", 64'(rvalid), 64'(0));
        chk("c_arready", 64'(arready), 64'(1));
        chk("c_bvalid_held", 64'(bvalid), 64'(1));
        chk("c_blocked3", 64'(wready_o), 64'(0));
        bready = 1;
        tick();
        bready = 0;
        chk("c_bvalid_clr", 64'(bvalid), 64'(0));
        chk("c_no_early2", 64'(wready_o), 64'(0));
        tick();
        chk("c_pulse2", 64'(wready_o), 64'(1));
        chk("c_bvalid2", 64'(bvalid), 64'(1));
        chk("c_waddr2", 64'(waddr_o), 64'h24);
        chk("c_wdata2", 64'(wdata_o), 64'h66);
        bready = 1;
        tick();
        bready = 0;
        chk("c_bvalid2_clr", 64'(bvalid), 64'(0));
        chk("c_pulse_cnt", 64'(pulse_cnt - p0), 64'(2));

        // reset in R_WAIT with AW held
        arvalid = 1; araddr = 15'h0008; awvalid = 1; awaddr = 15'h0030; rdata_i = 32'h99;
        tick();
        arvalid = 0; awvalid = 0;
        chk("x_awfull", 64'(awready), 64'(0));
        chk("x_rreq", 64'(rreq), 64'(1));
        tick();
        rst = 1;
        #1;
        chk("x_arready0", 64'(arready), 64'(0));
        chk("x_awready0", 64'(awready), 64'(0));
        chk("x_wready0", 64'(wready), 64'(0));
        chk("x_raddr0", 64'(raddr_o), 64'(0));
        chk("x_waddr0", 64'(waddr_o), 64'(0));
        chk("x_wdata0", 64'(wdata_o), 64'(0));
        chk("x_bvalid0", 64'(bvalid), 64'(0));
        chk("x_rvalid0", 64'(rvalid), 64'(0));
        tick();
        tick();
        rst = 0;
        p0 = pulse_cnt; b0 = b_cnt;
        chk("x_rel_awready", 64'(awready), 64'(0));
        tick();
        chk("x_awready1", 64'(awready), 64'(1));
        chk("x_wready1", 64'(wready), 64'(1));
        chk("x_arready1", 64'(arready), 64'(1));
        // a fresh W must not pair with the discarded AW
        wvalid = 1; wdata = 32'h1; wstrb = 4'hF; bready = 1; rready = 1;
        tick();
        wvalid = 0;
        for (int i = 0; i < 6; i++) begin
            chk("x_no_rreq", 64'(rreq), 64'(0));
            chk("x_no_rvalid", 64'(rvalid), 64'(0));
            chk("x_no_bvalid", 64'(bvalid), 64'(0));
            chk("x_no_pulse", 64'(wready_o), 64'(0));
            tick();
        end
        chk("x_pulse_cnt", 64'(pulse_cnt - p0), 64'(0));
        chk("x_b_cnt", 64'(b_cnt - b0), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
